// File: rtl/even_div_ctrl_pkg.sv
// Shared types and defaults for the programmable even clock divider controller.
package even_div_ctrl_pkg;

    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND
    } state_t;

endpackage

// File: rtl/div_half_cnt.sv
// Half-period counter: counts 0..cur_div-1, then wraps to 0 and toggles clk_out.
module div_half_cnt
    import even_div_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [CNT_W-1:0] cur_div,
    output logic             tc,
    output logic             clk_out
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lim;

    assign lim = cur_div - ONE;
    assign tc  = (cnt == lim);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (tc) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
        end else begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/even_div_ctrl.sv
// Runtime-programmable even clock divider controller (divide by 2*N, 50% duty).
// Optional tick output enabled by defining DIVCTL_TICK_EN.
module even_div_ctrl
    import even_div_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [CNT_W-1:0] req_div,
    output logic             req_ready,
    output logic             clk_out,
`ifdef DIVCTL_TICK_EN
    output logic             tick,
`endif
    output logic             busy
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cur_div, cur_div_nxt;
    logic [CNT_W-1:0] pend_div, pend_div_nxt;
    logic             xfer;
    logic             tc;
    logic             boundary;
    logic             cnt_clear;

    assign req_ready = (state != PEND);
    assign busy      = (state != IDLE);
    assign xfer      = req_valid && req_ready;
    // Ratio swaps and stops only happen on the falling toggle, so no runt pulses.
    assign boundary  = (state == PEND) && tc && clk_out;
    // Holding the counter clear while idle makes RUN start from cnt=0, clk_out=0.
    assign cnt_clear = (state == IDLE);

    div_half_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .cur_div(cur_div),
        .tc     (tc),
        .clk_out(clk_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cur_div  <= '0;
            pend_div <= '0;
        end else begin
            state    <= state_nxt;
            cur_div  <= cur_div_nxt;
            pend_div <= pend_div_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cur_div_nxt  = cur_div;
        pend_div_nxt = pend_div;
        case (state)
            IDLE: begin
                if (xfer && (req_div != '0)) begin
                    state_nxt   = RUN;
                    cur_div_nxt = req_div;
                end
            end
            RUN: begin
                if (xfer) begin
                    state_nxt    = PEND;
                    pend_div_nxt = req_div;
                end
            end
            PEND: begin
                if (boundary) begin
                    if (pend_div != '0) begin
                        state_nxt   = RUN;
                        cur_div_nxt = pend_div;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef DIVCTL_TICK_EN
    logic tick_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= !cnt_clear && tc && !clk_out;
        end
    end

    assign tick = tick_q;
`endif

endmodule

// File: tb/tb_even_div_ctrl.sv
// Scoreboard bench for even_div_ctrl: expected clk_out edges (and ticks) are queued
// by the stimulus; a negedge monitor pops and compares on each observed edge.
module tb_even_div_ctrl;
    localparam int unsigned CNT_W = 8;

    typedef struct {
        int   cyc;
        logic level;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic [CNT_W-1:0] req_div = '0;
    logic             req_ready;
    logic             clk_out;
    logic             busy;
`ifdef DIVCTL_TICK_EN
    logic             tick;
`endif

    even_div_ctrl #(
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_div  (req_div),
        .req_ready(req_ready),
        .clk_out  (clk_out),
`ifdef DIVCTL_TICK_EN
        .tick     (tick),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  ev_q[$];
    int   tick_q[$];
    bit   mon_en = 1'b0;
    logic prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cyc %0d: got %b, required %b", name, cyc, got, exp);
        end
    endtask

    task automatic push_edge(input int c, input logic lvl);
        ev_q.push_back('{c, lvl});
        if (lvl) tick_q.push_back(c);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Request transferred on posedge number e; returns at the negedge after edge e.
    task automatic xfer(input int n, input int e);
        wait_until(e - 1);
        req_valid = 1'b1;
        req_div   = n[CNT_W-1:0];
        check("ready_at_xfer", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        req_div   = '0;
    endtask

    // Monitor: compares every observed clk_out transition against the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (clk_out !== prev) begin
                n_cmp++;
                if (ev_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL edge_unexpected at cyc %0d: got level %b, required no edge", cyc, clk_out);
                end else begin
                    ev_t e;
                    e = ev_q.pop_front();
                    if (e.cyc != cyc || e.level !== clk_out) begin
                        n_bad++;
                        $display("FAIL edge_timing: got level %b at cyc %0d, required level %b at cyc %0d",
                                 clk_out, cyc, e.level, e.cyc);
                    end
                end
            end
            prev = clk_out;
`ifdef DIVCTL_TICK_EN
            if (tick !== 1'b0) begin
                n_cmp++;
                if (tick_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL tick_unexpected at cyc %0d: got %b, required 0", cyc, tick);
                end else begin
                    int t;
                    t = tick_q.pop_front();
                    if (t != cyc) begin
                        n_bad++;
                        $display("FAIL tick_timing: got tick at cyc %0d, required at cyc %0d", cyc, t);
                    end
                end
            end
`endif
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout at cyc %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, t1, t2, t3, t4;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_clk_out", clk_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", req_ready, 1'b1);
`ifdef DIVCTL_TICK_EN
        check("rst_tick", tick, 1'b0);
`endif
        prev   = 1'b0;
        mon_en = 1'b1;

        // N=5: three full periods, then stop requested during the low phase.
        t0 = cyc + 2;
        for (int p = 0; p < 3; p++) begin
            push_edge(t0 + 10 * p + 5, 1'b1);
            push_edge(t0 + 10 * p + 10, 1'b0);
        end
        push_edge(t0 + 35, 1'b1);
        push_edge(t0 + 40, 1'b0);
        xfer(5, t0);
        check("n5_busy", busy, 1'b1);
        xfer(0, t0 + 31);
        check("stop_ready_low", req_ready, 1'b0);
        check("stop_busy_high", busy, 1'b1);
        wait_until(t0 + 40);
        check("stop_busy", busy, 1'b0);
        check("stop_ready", req_ready, 1'b1);
        check("stop_clk_out", clk_out, 1'b0);

        // N=1: toggles every cycle, stop lands on the next falling toggle.
        t1 = t0 + 42;
        for (int p = 0; p < 4; p++) begin
            push_edge(t1 + 2 * p + 1, 1'b1);
            push_edge(t1 + 2 * p + 2, 1'b0);
        end
        xfer(1, t1);
        xfer(0, t1 + 6);
        wait_until(t1 + 7);
        check("n1_pend_ready", req_ready, 1'b0);
        wait_until(t1 + 8);
        check("n1_stop_busy", busy, 1'b0);

        // N=5 then N=2 requested in the high phase; a PEND request must be ignored.
        t2 = t1 + 10;
        push_edge(t2 + 5, 1'b1);
        push_edge(t2 + 10, 1'b0);
        push_edge(t2 + 15, 1'b1);
        push_edge(t2 + 20, 1'b0);
        push_edge(t2 + 22, 1'b1);
        push_edge(t2 + 24, 1'b0);
        push_edge(t2 + 26, 1'b1);
        push_edge(t2 + 28, 1'b0);
        push_edge(t2 + 30, 1'b1);
        push_edge(t2 + 32, 1'b0);
        xfer(5, t2);
        xfer(2, t2 + 17);
        req_valid = 1'b1;
        req_div   = 8'd7;
        check("pend_ready_17", req_ready, 1'b0);
        wait_until(t2 + 18);
        check("pend_ready_18", req_ready, 1'b0);
        wait_until(t2 + 19);
        check("pend_ready_19", req_ready, 1'b0);
        wait_until(t2 + 20);
        req_valid = 1'b0;
        req_div   = '0;
        check("boundary_ready", req_ready, 1'b1);
        xfer(0, t2 + 29);
        wait_until(t2 + 32);
        check("n2_stop_busy", busy, 1'b0);

        // N=3 re-requested: waveform unchanged; then reset mid-high with PEND active.
        t3 = t2 + 34;
        push_edge(t3 + 3, 1'b1);
        push_edge(t3 + 6, 1'b0);
        push_edge(t3 + 9, 1'b1);
        push_edge(t3 + 12, 1'b0);
        push_edge(t3 + 15, 1'b1);
        push_edge(t3 + 17, 1'b0);
        xfer(3, t3);
        xfer(3, t3 + 10);
        check("same_pend_ready", req_ready, 1'b0);
        wait_until(t3 + 12);
        check("same_ready_back", req_ready, 1'b1);
        xfer(4, t3 + 16);
        check("rst_pend_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_clk_out", clk_out, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", req_ready, 1'b1);
`ifdef DIVCTL_TICK_EN
        check("midrst_tick", tick, 1'b0);
`endif
        wait_until(t3 + 30);
        check("midrst_discard_busy", busy, 1'b0);
        check("midrst_discard_clk", clk_out, 1'b0);

        // N=255: full-width half period, stop requested in the low phase.
        t4 = t3 + 32;
        push_edge(t4 + 255, 1'b1);
        push_edge(t4 + 510, 1'b0);
        push_edge(t4 + 765, 1'b1);
        push_edge(t4 + 1020, 1'b0);
        xfer(255, t4);
        xfer(0, t4 + 600);
        wait_until(t4 + 700);
        check("max_pend_ready", req_ready, 1'b0);
        check("max_pend_busy", busy, 1'b1);
        wait_until(t4 + 1020);
        check("max_stop_busy", busy, 1'b0);
        check("max_stop_ready", req_ready, 1'b1);

        // N=0 in IDLE is accepted and does nothing.
        xfer(0, t4 + 1025);
        wait_until(t4 + 1030);
        check("idle_zero_busy", busy, 1'b0);

        wait_until(t4 + 1040);
        while (ev_q.size() != 0) begin
            ev_t e;
            e = ev_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL edge_missing: got no edge, required level %b at cyc %0d", e.level, e.cyc);
        end
`ifdef DIVCTL_TICK_EN
        while (tick_q.size() != 0) begin
            int t;
            t = tick_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL tick_missing: got no tick, required tick at cyc %0d", t);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/even_div_ctrl.md
# even_div_ctrl

Runtime-programmable even clock divider controller. It accepts divide-ratio requests over a valid/ready handshake and generates a 50%-duty divided output on the system clock. Ratio changes and stop requests take effect only at output period boundaries, so no runt pulses occur. It sits beside the fixed even dividers and provides the programmable divisor for downstream clock-enable consumers.

## Interface
Parameters:
- CNT_W, default 8: width of the half-period count. Supported divisors are 2·N for 1 ≤ N ≤ 2^CNT_W−1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  ratio request is valid.
- req_div  in  CNT_W  requested half-period N. 0 means stop.
- req_ready  out  1  controller can accept a request.
- clk_out  out  1  divided output, registered.
- tick  out  1  one-cycle pulse in the first cycle clk_out reads 1 (present only with the macro).
- busy  out  1  controller is not in IDLE.

## Operation
- States:
  - IDLE: divider stopped.
  - RUN: dividing by 2·cur_div.
  - PEND: new ratio held in pend_div, waiting for the period boundary.
- Transfer occurs on a cycle with req_valid && req_ready.
- req_ready = 1 in IDLE and RUN, 0 in PEND. Only one request can be outstanding.
- IDLE:
  - Transfer with N > 0: go to RUN with cur_div = N, cnt = 0, clk_out = 0.
  - Transfer with N = 0: accepted, no effect.
- RUN and PEND counting: cnt counts 0..cur_div−1. When cnt == cur_div−1, cnt wraps to 0 and clk_out toggles.
- RUN: a transfer latches pend_div = req_div and moves to PEND. clk_out continues unchanged.
- PEND: the period boundary is the cycle where cnt == cur_div−1 and clk_out == 1, i.e. the falling toggle. At that edge:
  - clk_out goes to 0 and cnt goes to 0.
  - If pend_div ≠ 0: cur_div = pend_div and the state returns to RUN.
  - If pend_div == 0: the state goes to IDLE.
- Re-requesting the same N in RUN is legal. It takes the PEND path and produces no visible change in clk_out.
- busy = (state != IDLE).
- Reset values: state IDLE, cnt 0, cur_div 0, pend_div 0, clk_out 0, tick 0, req_ready 1, busy 0.
- Reset asserted mid-operation wins over everything, including an in-flight transfer or boundary. The next edge returns all registers to their reset values.
- Arithmetic:
  - cnt and cur_div are CNT_W bits unsigned.
  - The compare uses cur_div−1 computed in CNT_W bits. cur_div is never 0 while in RUN or PEND.

## Timing
- Start latency: transfer at edge k → clk_out rises at edge k+N and falls at edge k+2N. Period is 2N cycles, N high and N low.
- N = 1: clk_out toggles every cycle (clk/2).
- Ratio change: the new ratio's first high phase begins N_new cycles after the boundary edge.
- Stop: clk_out is 0 and busy is 0 from the boundary edge onward.
- req_ready rises again on the boundary edge, so a new request can transfer on the cycle after the boundary.
- tick is registered and asserted exactly in the cycles where clk_out transitions 0→1.

## Configuration
- DIVCTL_TICK_EN defined: the tick port and its register exist, with behaviour as above.
- DIVCTL_TICK_EN undefined: the tick port and its logic are omitted. All other behaviour is identical.

## Structure
- Package even_div_ctrl_pkg contains:
  - the state enum typedef (IDLE, RUN, PEND);
  - the default CNT_W constant.
- One sub-module, div_half_cnt, holds cnt, the terminal-count compare and the clk_out toggle register. Its inputs are load/clear and cur_div; its outputs are tc and clk_out.
- The top level holds the FSM, the handshake, cur_div/pend_div and tick.

## Test plan
- Reset, then request N=5: req_ready=1, transfer at edge k; clk_out high on edges k+5..k+9, low on k+10..k+14; tick pulses every 10 cycles; busy=1.
- Request N=1 from IDLE: clk_out toggles every cycle from edge k+1 onward. Then request N=0: clk_out holds 0 and busy=0 after the next falling toggle.
- Running N=5, request N=2 during the high phase: req_ready=0 until the falling edge; a second req_valid during PEND is not accepted; after the boundary the output is 2 high / 2 low.
- Running N=3, request N=3 again: clk_out waveform is unchanged; req_ready drops for at most 6 cycles.
- Assert rst for one cycle mid-high with PEND active: the next edge gives clk_out=0, busy=0, req_ready=1, tick=0, and pend_div is discarded.
- N = 2^CNT_W−1 (255): high and low phases are each 255 cycles with no counter overflow; repeat with DIVCTL_TICK_EN undefined and confirm clk_out matches.
